// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multi-cycle op kinds, the canonical NOP word and
// the default multi-cycle latencies that the EX-stage units also use.
package cpu_pkg;

  typedef enum logic [1:0] {
    MC_NONE = 2'd0,
    MC_MUL  = 2'd1,
    MC_DIV  = 2'd2,
    MC_EXT  = 2'd3
  } mc_kind_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INS_DEF = 32'h0000_0013;

  localparam int LAT_MUL_DEF = 32;
  localparam int LAT_DIV_DEF = 34;
  localparam int LAT_EXT_DEF = 4;

endpackage

// File: rtl/mc_stall_counter.sv
// Multi-cycle operation down-counter. A start request is accepted only when
// the counter is idle and the kind is not MC_NONE; the counter then loads the
// latency for that kind and counts down to zero, saturating there.
module mc_stall_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int LAT_MUL = LAT_MUL_DEF,
  parameter int LAT_DIV = LAT_DIV_DEF,
  parameter int LAT_EXT = LAT_EXT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mc_start,
  input  logic [1:0] mc_kind,
  output logic       mc_busy,
  output logic       mc_done
);

  // Latencies wider than the counter are truncated; a latency of 0 loads 0,
  // so that op never raises busy.
  localparam logic [CNT_W-1:0] LAT_MUL_C = CNT_W'(LAT_MUL);
  localparam logic [CNT_W-1:0] LAT_DIV_C = CNT_W'(LAT_DIV);
  localparam logic [CNT_W-1:0] LAT_EXT_C = CNT_W'(LAT_EXT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lat_sel;
  logic             accept;

  // Latency lookup, accept decision and next counter value.
  always_comb begin
    lat_sel = '0;
    case (mc_kind)
      MC_MUL:  lat_sel = LAT_MUL_C;
      MC_DIV:  lat_sel = LAT_DIV_C;
      MC_EXT:  lat_sel = LAT_EXT_C;
      default: lat_sel = '0;
    endcase

    accept = mc_start && (mc_kind != MC_NONE) && (cnt_q == '0);

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = lat_sel;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register; reset clears any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign mc_busy = (cnt_q != '0);
  assign mc_done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipe_stage_reg_mc.sv
// Generic pipeline stage register carrying PC, instruction and valid.
// Supports hazard stall (en_reg=0), flush to a bubble, and a built-in
// multi-cycle stall counter. Flush beats stall; reset beats everything.
module pipe_stage_reg_mc
  import cpu_pkg::*;
#(
  parameter int                 PC_W    = 32,
  parameter int                 INS_W   = 32,
  parameter int                 CNT_W   = 8,
  parameter int                 LAT_MUL = LAT_MUL_DEF,
  parameter int                 LAT_DIV = LAT_DIV_DEF,
  parameter int                 LAT_EXT = LAT_EXT_DEF,
  parameter logic [INS_W-1:0]   NOP_INS = INS_W'(NOP_INS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_reg,
  input  logic             flush,
  input  logic             mc_start,
  input  logic [1:0]       mc_kind,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [INS_W-1:0] ins_in,
  input  logic             valid_in,
  output logic [PC_W-1:0]  pc_out,
  output logic [INS_W-1:0] ins_out,
  output logic             valid_out,
  output logic             mc_busy,
  output logic             mc_done,
  output logic             stall_out
);

  logic [PC_W-1:0]  pc_q,    pc_d;
  logic [INS_W-1:0] ins_q,   ins_d;
  logic             valid_q, valid_d;

  mc_stall_counter #(
    .CNT_W   (CNT_W),
    .LAT_MUL (LAT_MUL),
    .LAT_DIV (LAT_DIV),
    .LAT_EXT (LAT_EXT)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_kind  (mc_kind),
    .mc_busy  (mc_busy),
    .mc_done  (mc_done)
  );

  // The accept cycle itself does not stall: busy only rises after the edge.
  assign stall_out = ~en_reg | mc_busy;

  // Next stage contents: flush inserts a bubble but still tracks the PC.
  always_comb begin
    pc_d    = pc_q;
    ins_d   = ins_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = pc_in;
      ins_d   = NOP_INS;
      valid_d = 1'b0;
    end else if (!stall_out) begin
      pc_d    = pc_in;
      ins_d   = ins_in;
      valid_d = valid_in;
    end
  end

  // Stage register with synchronous reset to an invalid NOP at PC 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      ins_q   <= NOP_INS;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ins_q   <= ins_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign ins_out   = ins_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_pipe_stage_reg_mc.sv
// Bench for pipe_stage_reg_mc: a vector table for single-cycle behaviour plus
// hand-written multi-cycle sequences, all checked through a scoreboard queue.
module tb_pipe_stage_reg_mc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, en_reg, flush, mc_start, valid_in;
  logic [1:0]  mc_kind;
  logic [31:0] pc_in, ins_in;
  logic [31:0] pc_out, ins_out;
  logic        valid_out, mc_busy, mc_done, stall_out;

  always #5 clk = ~clk;

  pipe_stage_reg_mc #(
    .PC_W    (32),
    .INS_W   (32),
    .CNT_W   (8),
    .LAT_MUL (32),
    .LAT_DIV (34),
    .LAT_EXT (4),
    .NOP_INS (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_reg    (en_reg),
    .flush     (flush),
    .mc_start  (mc_start),
    .mc_kind   (mc_kind),
    .pc_in     (pc_in),
    .ins_in    (ins_in),
    .valid_in  (valid_in),
    .pc_out    (pc_out),
    .ins_out   (ins_out),
    .valid_out (valid_out),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done),
    .stall_out (stall_out)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        valid;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic        rst, en, flush, start;
    logic [1:0]  kind;
    logic [31:0] pc, ins;
    logic        valid;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  // Reference state of the stage and counter
  logic [31:0] m_pc, m_ins;
  logic        m_valid;
  int          m_cnt = 0;
  bit          m_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic int lat_of(input logic [1:0] k);
    case (k)
      2'd1:    return 32;
      2'd2:    return 34;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_step(input logic r, e, f, s, input logic [1:0] k,
                            input logic [31:0] p, i, input logic v);
    bit stall;
    stall = !e || (m_cnt != 0);
    if (r) begin
      m_pc = 32'h0; m_ins = NOP; m_valid = 1'b0; m_cnt = 0;
    end else begin
      if (f) begin
        m_pc = p; m_ins = NOP; m_valid = 1'b0;
      end else if (!stall) begin
        m_pc = p; m_ins = i; m_valid = v;
      end
      if (s && k != 2'd0 && m_cnt == 0) m_cnt = lat_of(k);
      else if (m_cnt != 0) m_cnt = m_cnt - 1;
    end
    m_known = 1;
  endtask

  task automatic step(input logic r, e, f, s, input logic [1:0] k,
                      input logic [31:0] p, i, input logic v,
                      input bit use_tbl, input exp_t tbl_e);
    exp_t x, got;
    @(negedge clk);
    rst = r; en_reg = e; flush = f; mc_start = s; mc_kind = k;
    pc_in = p; ins_in = i; valid_in = v;
    #1;
    if (m_known) chk("stall_out", {31'b0, stall_out}, {31'b0, (!e || m_cnt != 0)});
    model_step(r, e, f, s, k, p, i, v);
    if (use_tbl) x = tbl_e;
    else begin
      x.pc = m_pc; x.ins = m_ins; x.valid = m_valid;
      x.busy = (m_cnt != 0); x.done = (m_cnt == 1);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (mc_busy === 1'b1) busy_cnt++;
    if (mc_done === 1'b1) done_cnt++;
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: got empty queue, required one entry");
    end else begin
      got = sb.pop_front();
      chk("pc_out",    pc_out,                 got.pc);
      chk("ins_out",   ins_out,                got.ins);
      chk("valid_out", {31'b0, valid_out},     {31'b0, got.valid});
      chk("mc_busy",   {31'b0, mc_busy},       {31'b0, got.busy});
      chk("mc_done",   {31'b0, mc_done},       {31'b0, got.done});
    end
  endtask

  task automatic run(input logic r, e, f, s, input logic [1:0] k,
                     input logic [31:0] p, i, input logic v);
    exp_t dummy;
    dummy = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    step(r, e, f, s, k, p, i, v, 1'b0, dummy);
  endtask

  function automatic vec_t mk(input logic r, e, f, input logic [31:0] p, i,
                              input logic v, input logic [31:0] ep, ei,
                              input logic ev);
    vec_t t;
    t.rst = r; t.en = e; t.flush = f; t.start = 1'b0; t.kind = 2'd0;
    t.pc = p; t.ins = i; t.valid = v;
    t.e = '{ep, ei, ev, 1'b0, 1'b0};
    return t;
  endfunction

  vec_t tbl[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en_reg = 1'b1; flush = 1'b0; mc_start = 1'b0; mc_kind = 2'd0;
    pc_in = 32'h0; ins_in = 32'h0; valid_in = 1'b0;

    //            rst  en   fl   pc_in         ins_in        v     exp_pc        exp_ins       exp_v
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 32'h40,  32'hAAAA_AAAA, 1'b1, 32'h0,   NOP,           1'b0);
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 32'h40,  32'hAAAA_AAAA, 1'b1, 32'h0,   NOP,           1'b0);
    tbl[2] = mk(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
    tbl[3] = mk(1'b0, 1'b0, 1'b0, 32'h104, 32'h1111_1111, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1);
    tbl[4] = mk(1'b0, 1'b1, 1'b1, 32'h108, 32'h2222_2222, 1'b1, 32'h108, NOP,           1'b0);
    tbl[5] = mk(1'b0, 1'b0, 1'b1, 32'h10C, 32'h3333_3333, 1'b1, 32'h10C, NOP,           1'b0);
    tbl[6] = mk(1'b0, 1'b1, 1'b0, 32'h110, 32'h4444_4444, 1'b0, 32'h110, 32'h4444_4444, 1'b0);

    foreach (tbl[n])
      step(tbl[n].rst, tbl[n].en, tbl[n].flush, tbl[n].start, tbl[n].kind,
           tbl[n].pc, tbl[n].ins, tbl[n].valid, 1'b1, tbl[n].e);

    // Multiply: 32 busy cycles, one done cycle, held through N+32, load at N+33
    busy_cnt = 0; done_cnt = 0;
    run(0, 1, 0, 1, 2'd1, 32'h1FC, 32'hA0A0_A0A0, 1);
    for (int j = 0; j < 32; j++) run(0, 1, 0, 0, 2'd0, 32'h200, 32'hB0B0_B0B0, 1);
    chk("mul_pc_held", pc_out, 32'h1FC);
    run(0, 1, 0, 0, 2'd0, 32'h200, 32'hB0B0_B0B0, 1);
    chk("mul_pc_load", pc_out, 32'h200);
    chk("mul_busy_cycles", busy_cnt, 32);
    chk("mul_done_cycles", done_cnt, 1);

    // Divide with a flush at count 10 and an ignored start at count 5
    busy_cnt = 0; done_cnt = 0;
    run(0, 1, 0, 1, 2'd2, 32'h300, 32'hC0C0_C0C0, 1);
    for (int j = 0; j < 40 && m_cnt != 10; j++) run(0, 1, 0, 0, 2'd0, 32'h304, 32'hC1C1_C1C1, 1);
    run(0, 1, 1, 0, 2'd0, 32'h308, 32'hC2C2_C2C2, 1);
    chk("flush_ins", ins_out, NOP);
    chk("flush_valid", {31'b0, valid_out}, 32'h0);
    for (int j = 0; j < 40 && m_cnt != 5; j++) run(0, 1, 0, 0, 2'd0, 32'h30C, 32'hC3C3_C3C3, 1);
    run(0, 1, 0, 1, 2'd1, 32'h310, 32'hC4C4_C4C4, 1);
    for (int j = 0; j < 40 && m_cnt != 0; j++) run(0, 1, 0, 0, 2'd0, 32'h314, 32'hC5C5_C5C5, 1);
    run(0, 1, 0, 1, 2'd0, 32'h318, 32'hC6C6_C6C6, 1);
    run(0, 1, 0, 0, 2'd0, 32'h31C, 32'hC7C7_C7C7, 1);
    chk("div_busy_cycles", busy_cnt, 34);
    chk("div_done_cycles", done_cnt, 1);

    // Reset mid-operation, with a start request in the same cycle
    run(0, 1, 0, 1, 2'd1, 32'h400, 32'hD0D0_D0D0, 1);
    for (int j = 0; j < 40 && m_cnt != 20; j++) run(0, 1, 0, 0, 2'd0, 32'h404, 32'hD1D1_D1D1, 1);
    run(1, 1, 0, 1, 2'd1, 32'h408, 32'hD2D2_D2D2, 1);
    chk("rst_mid_busy", {31'b0, mc_busy}, 32'h0);
    chk("rst_mid_ins", ins_out, NOP);
    run(0, 1, 0, 0, 2'd0, 32'h40C, 32'hD3D3_D3D3, 1);

    // Accept and flush in the same cycle, then drain the extended op
    run(0, 1, 1, 1, 2'd3, 32'h500, 32'hE0E0_E0E0, 1);
    for (int j = 0; j < 6; j++) run(0, 1, 0, 0, 2'd0, 32'h504, 32'hE1E1_E1E1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
